// File: rtl/wb_pkg.sv
// Shared helpers for the Wishbone decoder slice: safe widths for slave
// indices and outstanding-transaction counters.
package wb_pkg;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder: maps a word address onto a slave index, lowest index wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                   AddrWidth = 30,
    parameter int                   Count     = 2,
    parameter logic [AddrWidth-1:0] BaseAddr [Count] = '{default: '0},
    parameter logic [AddrWidth-1:0] AddrMask [Count] = '{default: '0},
    localparam int                  IdxWidth  = idx_width(Count)
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic [Count-1:0]     hit_o,
    output logic [IdxWidth-1:0]  idx_o,
    output logic                 unmapped_o
);

    always_comb begin
        hit_o      = '0;
        idx_o      = '0;
        unmapped_o = 1'b1;
        for (int i = 0; i < Count; i++) begin
            hit_o[i] = (addr_i & AddrMask[i]) == BaseAddr[i];
        end
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = Count - 1; i >= 0; i--) begin
            if (hit_o[i]) begin
                idx_o      = IdxWidth'(i);
                unmapped_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// Pipelined Wishbone 1-to-Count decoder with in-order response routing.
// Latency: zero added cycles on request/response paths; unmapped err after 1 cycle.
// Backpressure: stalls master on target switch, full outstanding window, or slave stall.
module wb_decoder
    import wb_pkg::*;
#(
    parameter int                   DataWidth      = 32,
    parameter int                   AddrWidth      = 30,
    parameter int                   Count          = 2,
    parameter int                   MaxOutstanding = 4,
    parameter logic [AddrWidth-1:0] BaseAddr [Count] = '{default: '0},
    parameter logic [AddrWidth-1:0] AddrMask [Count] = '{default: '0},
    localparam int                  SelWidth       = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] wb_m_data_i,
    input  logic [AddrWidth-1:0] wb_m_addr_i,
    input  logic [SelWidth-1:0]  wb_m_sel_i,
    input  logic                 wb_m_cyc_i,
    input  logic                 wb_m_stb_i,
    input  logic                 wb_m_we_i,
    output logic [DataWidth-1:0] wb_m_data_o,
    output logic                 wb_m_ack_o,
    output logic                 wb_m_stall_o,
    output logic                 wb_m_err_o,
    output logic [DataWidth-1:0] wb_s_data_o [Count],
    output logic [AddrWidth-1:0] wb_s_addr_o [Count],
    output logic [SelWidth-1:0]  wb_s_sel_o  [Count],
    output logic [Count-1:0]     wb_s_cyc_o,
    output logic [Count-1:0]     wb_s_stb_o,
    output logic [Count-1:0]     wb_s_we_o,
    input  logic [DataWidth-1:0] wb_s_data_i [Count],
    input  logic [Count-1:0]     wb_s_ack_i,
    input  logic [Count-1:0]     wb_s_stall_i,
    input  logic [Count-1:0]     wb_s_err_i
);

    localparam int IdxWidth = idx_width(Count);
    localparam int CntWidth = cnt_width(MaxOutstanding);
    localparam logic [CntWidth-1:0] PendMax = CntWidth'(MaxOutstanding);

    typedef logic [IdxWidth-1:0] slv_idx_t;

    slv_idx_t            sel_idx_q, sel_idx_d;
    logic                sel_vld_q, sel_vld_d;
    logic [CntWidth-1:0] pend_q, pend_d;
    logic                uerr_q, uerr_d;

    logic [Count-1:0] dec_hit;
    slv_idx_t         dec_idx;
    logic             dec_unmapped;

    logic     live, req, pend_nz, tgt_vld, mismatch, full, stall, accept;
    logic     resp_ack, resp_err, resp_uerr, resp;
    slv_idx_t tgt_idx;

    wb_addr_decode #(
        .AddrWidth (AddrWidth),
        .Count     (Count),
        .BaseAddr  (BaseAddr),
        .AddrMask  (AddrMask)
    ) u_addr_decode (
        .addr_i     (wb_m_addr_i),
        .hit_o      (dec_hit),
        .idx_o      (dec_idx),
        .unmapped_o (dec_unmapped)
    );

    always_comb begin
        live      = !rst_i;
        req       = live && wb_m_cyc_i && wb_m_stb_i;
        pend_nz   = pend_q != '0;
        tgt_vld   = pend_nz ? sel_vld_q : |dec_hit;
        tgt_idx   = pend_nz ? sel_idx_q : dec_idx;
        resp_ack  = live && pend_nz && sel_vld_q && wb_s_ack_i[sel_idx_q];
        resp_err  = live && pend_nz && sel_vld_q && wb_s_err_i[sel_idx_q];
        resp_uerr = live && uerr_q;
        resp      = resp_ack || resp_err || resp_uerr;
        // While anything is in flight only the same mapped slave may be targeted.
        mismatch  = pend_nz && (dec_unmapped || !sel_vld_q || dec_idx != sel_idx_q);
        full      = (pend_q == PendMax) && !resp;
        stall     = req && (mismatch || full || (tgt_vld && wb_s_stall_i[tgt_idx]));
        accept    = req && !stall;
    end

    always_comb begin
        wb_m_stall_o = stall;
        wb_m_ack_o   = resp_ack;
        wb_m_err_o   = resp_err || resp_uerr;
        wb_m_data_o  = sel_vld_q ? wb_s_data_i[sel_idx_q] : '0;
        for (int i = 0; i < Count; i++) begin
            wb_s_data_o[i] = wb_m_data_i;
            wb_s_addr_o[i] = wb_m_addr_i;
            wb_s_sel_o[i]  = wb_m_sel_i;
            wb_s_we_o[i]   = wb_m_we_i;
            wb_s_stb_o[i]  = accept && tgt_vld && (tgt_idx == slv_idx_t'(i));
            wb_s_cyc_o[i]  = live && wb_m_cyc_i &&
                             ((pend_nz && sel_vld_q && sel_idx_q == slv_idx_t'(i)) ||
                              (!pend_nz && !dec_unmapped && dec_idx == slv_idx_t'(i) && wb_m_stb_i));
        end
    end

    always_comb begin
        sel_vld_d = sel_vld_q;
        sel_idx_d = sel_idx_q;
        uerr_d    = 1'b0;
        pend_d    = pend_q + CntWidth'(accept) - CntWidth'(resp);
        if (accept) begin
            sel_vld_d = tgt_vld;
            sel_idx_d = tgt_idx;
            uerr_d    = !tgt_vld;
        end
        // Dropping cyc abandons the whole window; late slave responses are ignored.
        if (!wb_m_cyc_i) begin
            sel_vld_d = 1'b0;
            sel_idx_d = '0;
            pend_d    = '0;
            uerr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_vld_q <= 1'b0;
            sel_idx_q <= '0;
            pend_q    <= '0;
            uerr_q    <= 1'b0;
        end else begin
            sel_vld_q <= sel_vld_d;
            sel_idx_q <= sel_idx_d;
            pend_q    <= pend_d;
            uerr_q    <= uerr_d;
        end
    end

endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed scenarios plus a randomized run
// against a queue-based model of the outstanding-transaction window.
module tb_wb_decoder;

    localparam int MAXO = 4;
    localparam logic [29:0] BASE [2] = '{30'h0000_0000, 30'h0000_0100};
    localparam logic [29:0] MASK [2] = '{30'h3FFF_FF00, 30'h0000_3F00};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_data;
    logic [29:0] m_addr;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_data_o;
    logic        m_ack, m_stall, m_err;
    logic [31:0] s_data_o [2];
    logic [29:0] s_addr_o [2];
    logic [3:0]  s_sel_o  [2];
    logic [1:0]  s_cyc, s_stb, s_we_o;
    logic [31:0] s_data [2];
    logic [1:0]  s_ack, s_stall, s_err;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_decoder #(
        .DataWidth      (32),
        .AddrWidth      (30),
        .Count          (2),
        .MaxOutstanding (MAXO),
        .BaseAddr       (BASE),
        .AddrMask       (MASK)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb_m_data_i  (m_data),
        .wb_m_addr_i  (m_addr),
        .wb_m_sel_i   (m_sel),
        .wb_m_cyc_i   (m_cyc),
        .wb_m_stb_i   (m_stb),
        .wb_m_we_i    (m_we),
        .wb_m_data_o  (m_data_o),
        .wb_m_ack_o   (m_ack),
        .wb_m_stall_o (m_stall),
        .wb_m_err_o   (m_err),
        .wb_s_data_o  (s_data_o),
        .wb_s_addr_o  (s_addr_o),
        .wb_s_sel_o   (s_sel_o),
        .wb_s_cyc_o   (s_cyc),
        .wb_s_stb_o   (s_stb),
        .wb_s_we_o    (s_we_o),
        .wb_s_data_i  (s_data),
        .wb_s_ack_i   (s_ack),
        .wb_s_stall_i (s_stall),
        .wb_s_err_i   (s_err)
    );

    initial forever #5 clk = ~clk;

    function automatic int ref_decode(input logic [29:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_sel = '1;
        s_ack = '0; s_err = '0; s_stall = '0;
        s_data[0] = 32'hA0A0_A0A0; s_data[1] = 32'hB1B1_B1B1;
    endtask

    task automatic drive_req(input logic [29:0] a, input logic we);
        m_cyc = 1'b1; m_stb = 1'b1; m_addr = a; m_we = we; m_data = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        drive_req(30'h104, 1'b0);
        tick(); #4;
        n_cmp++; if (s_cyc !== 2'b00 || s_stb !== 2'b00) begin n_fail++; $display("FAIL reset_slave_cyc_stb: got cyc=%b stb=%b want 00/00", s_cyc, s_stb); end
        n_cmp++; if (m_ack !== 1'b0 || m_err !== 1'b0 || m_stall !== 1'b0) begin n_fail++; $display("FAIL reset_master_resp: got ack=%b err=%b stall=%b want 0/0/0", m_ack, m_err, m_stall); end
        n_cmp++; if (m_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data_o); end
        tick();
        rst = 1'b0;
        idle_inputs();
        #4;
        n_cmp++; if (int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL reset_pend: got %0d want 0", dut.pend_q); end
        tick();
    endtask

    task automatic test_single_read();
        idle_inputs();
        drive_req(30'h104, 1'b0);
        s_data[1] = 32'hDEAD_BEEF; s_data[0] = 32'h1234_5678;
        #4;
        n_cmp++; if (m_stall !== 1'b0 || s_cyc !== 2'b10 || s_stb !== 2'b10) begin n_fail++; $display("FAIL read_issue: got stall=%b cyc=%b stb=%b want 0/10/10", m_stall, s_cyc, s_stb); end
        tick(); m_stb = 1'b0; #4;
        n_cmp++; if (m_ack !== 1'b0 || s_cyc !== 2'b10 || s_stb !== 2'b00) begin n_fail++; $display("FAIL read_wait: got ack=%b cyc=%b stb=%b want 0/10/00", m_ack, s_cyc, s_stb); end
        tick(); s_ack = 2'b10; #4;
        n_cmp++; if (m_ack !== 1'b1 || m_err !== 1'b0) begin n_fail++; $display("FAIL read_ack: got ack=%b err=%b want 1/0", m_ack, m_err); end
        n_cmp++; if (m_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", m_data_o); end
        tick(); idle_inputs(); #4;
        n_cmp++; if (int'(dut.pend_q) != 0 || m_ack !== 1'b0) begin n_fail++; $display("FAIL read_done: got pend=%0d ack=%b want 0/0", dut.pend_q, m_ack); end
        tick();
    endtask

    task automatic test_burst();
        int peak = 0;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive_req(30'h10 + 30'(k), 1'b1);
            else m_stb = 1'b0;
            s_ack = (k > 0) ? 2'b01 : 2'b00;
            #4;
            if (k < 4) begin
                n_cmp++; if (m_stall !== 1'b0 || s_stb !== 2'b01) begin n_fail++; $display("FAIL burst_issue k=%0d: got stall=%b stb=%b want 0/01", k, m_stall, s_stb); end
            end
            if (k > 0) begin
                n_cmp++; if (m_ack !== 1'b1) begin n_fail++; $display("FAIL burst_ack k=%0d: got %b want 1", k, m_ack); end
            end
            if (int'(dut.pend_q) > peak) peak = int'(dut.pend_q);
            tick();
        end
        s_ack = 2'b00; #4;
        n_cmp++; if (peak != 1) begin n_fail++; $display("FAIL burst_peak: got %0d want 1", peak); end
        n_cmp++; if (int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL burst_drain: got %0d want 0", dut.pend_q); end
        idle_inputs(); tick();
    endtask

    task automatic test_full();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            drive_req(30'h20 + 30'(k), 1'b1); #4;
            n_cmp++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL full_fill k=%0d: got stall=%b want 0", k, m_stall); end
            tick();
        end
        drive_req(30'h24, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #4;
            n_cmp++; if (m_stall !== 1'b1 || s_stb !== 2'b00) begin n_fail++; $display("FAIL full_stall k=%0d: got stall=%b stb=%b want 1/00", k, m_stall, s_stb); end
            tick();
        end
        s_ack = 2'b01; #4;
        n_cmp++; if (m_stall !== 1'b0 || s_stb !== 2'b01 || m_ack !== 1'b1) begin n_fail++; $display("FAIL full_release: got stall=%b stb=%b ack=%b want 0/01/1", m_stall, s_stb, m_ack); end
        tick();
        m_stb = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        s_ack = 2'b00; #4;
        n_cmp++; if (int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", dut.pend_q); end
        idle_inputs(); tick();
    endtask

    task automatic test_switch();
        idle_inputs();
        drive_req(30'h30, 1'b0); #4;
        n_cmp++; if (m_stall !== 1'b0 || s_stb !== 2'b01) begin n_fail++; $display("FAIL switch_first: got stall=%b stb=%b want 0/01", m_stall, s_stb); end
        tick(); drive_req(30'h140, 1'b0); #4;
        n_cmp++; if (m_stall !== 1'b1 || s_stb !== 2'b00 || s_cyc !== 2'b01) begin n_fail++; $display("FAIL switch_block: got stall=%b stb=%b cyc=%b want 1/00/01", m_stall, s_stb, s_cyc); end
        tick(); s_ack = 2'b01; #4;
        n_cmp++; if (m_stall !== 1'b1 || m_ack !== 1'b1) begin n_fail++; $display("FAIL switch_ackcycle: got stall=%b ack=%b want 1/1", m_stall, m_ack); end
        tick(); s_ack = 2'b00; #4;
        n_cmp++; if (int'(dut.pend_q) != 0 || m_stall !== 1'b0 || s_stb !== 2'b10 || s_cyc !== 2'b10) begin n_fail++; $display("FAIL switch_issue: got pend=%0d stall=%b stb=%b cyc=%b want 0/0/10/10", dut.pend_q, m_stall, s_stb, s_cyc); end
        tick(); m_stb = 1'b0; s_ack = 2'b10; #4;
        n_cmp++; if (m_ack !== 1'b1) begin n_fail++; $display("FAIL switch_ack2: got %b want 1", m_ack); end
        tick(); idle_inputs(); tick();
    endtask

    task automatic test_unmapped();
        idle_inputs();
        drive_req(30'h3FFF_0000, 1'b0); #4;
        n_cmp++; if (m_stall !== 1'b0 || s_stb !== 2'b00 || s_cyc !== 2'b00 || m_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_issue: got stall=%b stb=%b cyc=%b err=%b want 0/00/00/0", m_stall, s_stb, s_cyc, m_err); end
        tick(); m_stb = 1'b0; #4;
        n_cmp++; if (m_err !== 1'b1 || m_ack !== 1'b0) begin n_fail++; $display("FAIL unmapped_err: got err=%b ack=%b want 1/0", m_err, m_ack); end
        tick(); #4;
        n_cmp++; if (m_err !== 1'b0 || int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL unmapped_once: got err=%b pend=%0d want 0/0", m_err, dut.pend_q); end
        idle_inputs(); tick();
    endtask

    task automatic test_abort();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            drive_req(30'h150 + 30'(k), 1'b0); #4;
            n_cmp++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL abort_fill k=%0d: got stall=%b want 0", k, m_stall); end
            tick();
        end
        m_cyc = 1'b0; m_stb = 1'b0; #4;
        n_cmp++; if (s_cyc !== 2'b00 || s_stb !== 2'b00 || int'(dut.pend_q) != 2) begin n_fail++; $display("FAIL abort_drop: got cyc=%b stb=%b pend=%0d want 00/00/2", s_cyc, s_stb, dut.pend_q); end
        tick(); s_ack = 2'b10; #4;
        n_cmp++; if (m_ack !== 1'b0 || int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL abort_late_ack: got ack=%b pend=%0d want 0/0", m_ack, dut.pend_q); end
        idle_inputs(); tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            drive_req(30'h40 + 30'(k), 1'b0); tick();
        end
        rst = 1'b1; m_stb = 1'b0; tick();
        rst = 1'b0; drive_req(30'h160, 1'b0); s_ack = 2'b01; #4;
        n_cmp++; if (m_ack !== 1'b0 || m_err !== 1'b0 || m_data_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_resp: got ack=%b err=%b data=%h want 0/0/0", m_ack, m_err, m_data_o); end
        n_cmp++; if (m_stall !== 1'b0 || s_stb !== 2'b10 || int'(dut.pend_q) != 0) begin n_fail++; $display("FAIL rstmid_accept: got stall=%b stb=%b pend=%0d want 0/10/0", m_stall, s_stb, dut.pend_q); end
        tick(); m_stb = 1'b0; s_ack = 2'b10; #4;
        n_cmp++; if (m_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %b want 1", m_ack); end
        tick(); idle_inputs(); tick();
    endtask

    task automatic test_random();
        int         oq[$];
        bit         uerr_due = 1'b0;
        int         scnt[2] = '{0, 0};
        int         abort_left = 0;
        int         dec, tgt;
        bit         e_stall, e_ack, e_err, e_acc, resp_any;
        logic [1:0] e_stb, e_cyc;
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            s_ack = '0; s_err = '0;
            if (abort_left == 0 && $urandom_range(0, 59) == 0) abort_left = 2;
            if (abort_left > 0) begin
                m_cyc = 1'b0; m_stb = 1'b0; s_stall = '0;
                if (abort_left == 1) begin
                    for (int i = 0; i < 2; i++) if (scnt[i] > 0) s_ack[i] = 1'b1;
                end
            end else begin
                m_cyc = 1'b1;
                m_stb = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 9))
                    0:             m_addr = {1'b1, 15'($urandom), 6'h3F, 8'($urandom)};
                    1, 2, 3, 4, 5: m_addr = 30'($urandom_range(0, 255));
                    default:       m_addr = {16'($urandom), 6'h01, 8'($urandom)};
                endcase
                m_we = 1'($urandom); m_data = $urandom; m_sel = 4'($urandom);
                for (int i = 0; i < 2; i++) begin
                    s_stall[i] = ($urandom_range(0, 4) == 0);
                    if (scnt[i] > 0 && $urandom_range(0, 1) == 1) begin
                        if ($urandom_range(0, 9) == 0) s_err[i] = 1'b1;
                        else s_ack[i] = 1'b1;
                    end
                end
            end
            s_data[0] = $urandom; s_data[1] = $urandom;
            #4;
            dec      = ref_decode(m_addr);
            e_ack    = oq.size() > 0 && oq[0] >= 0 && s_ack[oq[0]];
            e_err    = (oq.size() > 0 && oq[0] >= 0 && s_err[oq[0]]) || uerr_due;
            resp_any = e_ack || e_err;
            tgt      = (oq.size() == 0) ? dec : oq[0];
            e_stall  = m_cyc && m_stb && ((oq.size() > 0 && (dec < 0 || dec != oq[0])) ||
                       (oq.size() == MAXO && !resp_any) || (tgt >= 0 && s_stall[tgt]));
            e_acc    = m_cyc && m_stb && !e_stall;
            for (int i = 0; i < 2; i++) begin
                e_stb[i] = e_acc && tgt == i;
                e_cyc[i] = m_cyc && ((oq.size() > 0 && oq[0] == i) || (oq.size() == 0 && dec == i && m_stb));
            end
            n_cmp++; if (m_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, m_stall, e_stall); end
            n_cmp++; if (m_ack !== e_ack || m_err !== e_err) begin n_fail++; $display("FAIL rnd_resp n=%0d: got ack=%b err=%b want %b/%b", n, m_ack, m_err, e_ack, e_err); end
            n_cmp++; if (s_stb !== e_stb || s_cyc !== e_cyc) begin n_fail++; $display("FAIL rnd_route n=%0d: got stb=%b cyc=%b want %b/%b", n, s_stb, s_cyc, e_stb, e_cyc); end
            n_cmp++; if (int'(dut.pend_q) != oq.size()) begin n_fail++; $display("FAIL rnd_pend n=%0d: got %0d want %0d", n, dut.pend_q, oq.size()); end
            n_cmp++; if (s_addr_o[1] !== m_addr || s_we_o !== {2{m_we}} || s_data_o[0] !== m_data) begin n_fail++; $display("FAIL rnd_bcast n=%0d: got addr=%h we=%b want %h/%b", n, s_addr_o[1], s_we_o, m_addr, m_we); end
            if (e_ack) begin
                n_cmp++; if (m_data_o !== s_data[oq[0]]) begin n_fail++; $display("FAIL rnd_data n=%0d: got %h want %h", n, m_data_o, s_data[oq[0]]); end
            end
            for (int i = 0; i < 2; i++) begin
                if (s_ack[i] || s_err[i]) scnt[i]--;
                if (e_stb[i]) scnt[i]++;
            end
            if (abort_left == 1) scnt = '{0, 0};
            if (!m_cyc) begin
                oq.delete();
                uerr_due = 1'b0;
            end else begin
                if (resp_any) void'(oq.pop_front());
                if (e_acc) oq.push_back(tgt);
                uerr_due = e_acc && tgt < 0;
            end
            if (abort_left > 0) abort_left--;
            tick();
        end
        idle_inputs(); tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_burst();
        test_full();
        test_switch();
        test_unmapped();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
Name: wb_decoder

Overview:
- Single pipelined Wishbone master port fanned out to Count slave ports by address: the inverse of the many-to-one arbiter.
- Sits between the arbiter's shared bus and the peripherals/memories.
- Tracks outstanding transactions so each ack/err/data returns from the slave that was issued the request.
- Stalls the master when switching targets until the previous target drains; unmapped addresses get a local err.

Parameters:
- DataWidth, 32, data bus width; SelWidth = DataWidth/8 (localparam).
- AddrWidth, 30, word address width.
- Count, 2, number of slave ports (≥1).
- MaxOutstanding, 4, max in-flight requests (≥1); counter width $clog2(MaxOutstanding+1).
- BaseAddr, '{default:0}, [Count] array of AddrWidth-bit base addresses.
- AddrMask, '{default:0}, [Count] array of AddrWidth-bit masks; slave i hits when (addr & AddrMask[i]) == BaseAddr[i].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- wb_m_data_i/addr_i/sel_i/cyc_i/stb_i/we_i  in  DataWidth/AddrWidth/SelWidth/1/1/1  request from upstream master.
- wb_m_data_o/ack_o/stall_o/err_o  out  DataWidth/1/1/1  response to master.
- wb_s_data_o/addr_o/sel_o/cyc_o/stb_o/we_o  out  [Count] x same widths  request to slave i.
- wb_s_data_i/ack_i/stall_i/err_i  in  [Count] x same widths  response from slave i.

Behaviour:
- Decode: combinational; lowest-index hit wins; no hit = unmapped.
- State: sel_q (slave index + valid), pend_q (outstanding count), uerr_q (unmapped err due next cycle).
- Reset: sel_q invalid, pend_q=0, uerr_q=0. All slave cyc/stb=0; ack_o=err_o=0; stall_o=0; data_o=0.
- Target: tgt = (pend_q==0) ? decode(addr) : sel_q.
- stall_o=1 when wb_m_cyc_i && wb_m_stb_i && any of:
  - pend_q≠0 and decode(addr) ≠ sel_q (includes unmapped while pending);
  - pend_q==MaxOutstanding and no response this cycle;
  - stall_i of the mapped target.
- Issue: stb_o[tgt] = wb_m_stb_i && !stall_o. addr/data/sel/we are broadcast to all slaves.
- cyc_o[i] = wb_m_cyc_i && ((pend_q≠0 && sel_q==i) || (pend_q==0 && decode==i && wb_m_stb_i)).
- Accepted mapped request: sel_q<=tgt, pend_q+1 (net of a same-cycle response).
- Accepted unmapped request:
  - never reaches any slave;
  - uerr_q<=1, so err_o=1 exactly one cycle later;
  - counts in pend_q until that err.
- Response: ack_o = ack_i[sel_q] && pend_q≠0; err_o = (err_i[sel_q] && pend_q≠0) || uerr_q; data_o = data_i[sel_q], 0 when sel_q invalid. Each ack/err decrements pend_q.
- Simultaneous issue + response: pend_q unchanged. Counter never wraps; stall guarantees ≤MaxOutstanding.
- wb_m_cyc_i low: all slave cyc_o low the same cycle; next cycle pend_q=0, sel_q invalid, uerr_q=0. Late slave acks and acks with pend_q==0 are ignored, never forwarded.
- rst_i mid-transaction: same as cycle abort; outputs at reset values next cycle.
- Latency: zero added cycles on the request and response paths (combinational routing); unmapped err 1 cycle.

Decomposition:
- Shared package wb_pkg: widths-independent typedefs are not needed. Add localparam helper function clog2-safe counter width and a slave-index typedef parameterised via Count in-module.
- One sub-module: wb_addr_decode. Pure combinational; takes addr, BaseAddr, AddrMask; returns hit vector, index, and unmapped flag. Reused by the formal bench.

Test Plan:
- Single read to slave 1 (BaseAddr[1]=0x100, AddrMask[1]=0x3F00), addr 0x104, slave acks after 2 cycles with 0xDEADBEEF. Required: only cyc_o[1]/stb_o[1] high; ack_o and data_o=0xDEADBEEF in the same cycle as the slave ack.
- Pipelined burst: 4 writes to slave 0, slave acks each one cycle later. Required: stall_o stays 0 and pend_q peaks at 1. Then a 5th request with slave holding all acks and MaxOutstanding=4: required stall_o=1 until the first ack.
- Target switch: request to slave 0 then immediately to slave 1. Required: second request stalled until slave 0 acks, and it issues on the cycle pend_q returns to 0.
- Unmapped addr 0x3FFF_0000. Required: no slave stb; err_o=1 the next cycle for exactly one cycle; pend_q returns to 0.
- Abort: drop wb_m_cyc_i with 2 outstanding, slave then acks. Required: cyc_o low in the same cycle, the late ack is not forwarded, pend_q=0.
- Assert rst_i with 3 outstanding. Required: next cycle all outputs at reset values, and a new request is accepted immediately after.
